// File: rtl/crc8_frame_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// crc8_frame_arbiter_pkg
// Shared definitions for the two-requester CRC-8 frame arbiter:
//   - arb_state_t       : arbiter FSM state encoding (IDLE / RUN / DONE)
//   - CRC8_POLY_DEFAULT : default generator polynomial (x^8 implicit)
//   - CRC8_INIT_DEFAULT : default CRC preset loaded at frame start
//   - NUM_REQ           : number of requesters
//   - crc8_step()       : one byte of MSB-first, unreflected CRC-8
// -----------------------------------------------------------------------------
package crc8_frame_arbiter_pkg;

  localparam int         NUM_REQ           = 2;
  localparam logic [7:0] CRC8_POLY_DEFAULT = 8'h07;
  localparam logic [7:0] CRC8_INIT_DEFAULT = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

  // Feeds one byte MSB-first through the CRC register. No input/output
  // reflection and no final XOR.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                           input logic [7:0] din,
                                           input logic [7:0] poly);
    logic [7:0] c;
    logic [7:0] d;
    logic       fb;
    // NOTE: blocking assignments are correct here: each unrolled iteration
    // must see the result of the previous one, all within a single evaluation.
    c = crc;
    d = din;
    for (int i = 0; i < 8; i++) begin
      fb = c[7] ^ d[7];
      c  = {c[6:0], 1'b0} ^ (fb ? poly : 8'h00);
      d  = {d[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/crc8_frame_arbiter_accum.sv
// -----------------------------------------------------------------------------
// crc8_accum
// Running CRC-8 register for the arbiter datapath.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high; presets crc to INIT
//   clear : synchronous preset to INIT (start of a frame)
//   en    : fold din into the CRC this cycle (ignored while clear is high)
//   din   : byte to accumulate
//   crc   : current CRC value
// -----------------------------------------------------------------------------
module crc8_accum
  import crc8_frame_arbiter_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY_DEFAULT,
  parameter logic [7:0] INIT = CRC8_INIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] crc
);

  logic [7:0] r_crc;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_crc <= INIT;
    end else if (clear) begin
      r_crc <= INIT;
    end else if (en) begin
      r_crc <= crc8_step(r_crc, din, POLY);
    end
  end

  assign crc = r_crc;

endmodule

// File: rtl/crc8_frame_arbiter.sv
// -----------------------------------------------------------------------------
// crc8_frame_arbiter
// Round-robin arbiter between two byte-stream requesters. The granted
// requester streams one frame; its bytes are folded into a CRC-8 and the
// final CRC is reported with a one-cycle crc_valid pulse.
//   clk, reset           : clock (rising edge), async active-high reset
//   reqN_valid/data/last : requester N byte stream (N = 0, 1)
//   reqN_ready           : byte accepted when high together with reqN_valid
//   crc_out              : CRC of the last completed frame (held)
//   crc_valid            : one-cycle pulse qualifying crc_out / crc_id
//   crc_id               : requester that owned the completed frame (held)
//   busy                 : high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module crc8_frame_arbiter
  import crc8_frame_arbiter_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY_DEFAULT,
  parameter logic [7:0] INIT = CRC8_INIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] crc_out,
  output logic       crc_valid,
  output logic       crc_id,
  output logic       busy
);

  arb_state_t         r_state;
  logic               r_grant;
  logic               r_last_grant;
  logic [NUM_REQ-1:0] r_ready;
  logic [7:0]         r_crc_out;
  logic               r_crc_valid;
  logic               r_crc_id;
  logic               r_busy;

  logic               w_valid;
  logic               w_last;
  logic [7:0]         w_din;
  logic               w_any_valid;
  logic               w_grant_next;
  logic               w_clear;
  logic               w_fire;
  logic [7:0]         w_crc;
  logic [7:0]         w_crc_next;

  // Only the granted requester's stream reaches the datapath; the other
  // requester is invisible until the frame completes.
  assign w_valid     = r_grant ? req1_valid : req0_valid;
  assign w_last      = r_grant ? req1_last  : req0_last;
  assign w_din       = r_grant ? req1_data  : req0_data;
  assign w_any_valid = req0_valid | req1_valid;

  // On a tie, the requester not granted last wins; a lone requester wins
  // regardless of history.
  assign w_grant_next = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;

  assign w_clear = (r_state == ST_IDLE) & w_any_valid;
  assign w_fire  = (r_state == ST_RUN) & w_valid & r_ready[r_grant];

  crc8_accum #(
    .POLY (POLY),
    .INIT (INIT)
  ) u_accum (
    .clk   (clk),
    .reset (reset),
    .clear (w_clear),
    .en    (w_fire),
    .din   (w_din),
    .crc   (w_crc)
  );

  // crc_out must include the last byte, which the accumulator only absorbs
  // on the same edge, so the final value is computed ahead here.
  assign w_crc_next = crc8_step(w_crc, w_din, POLY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_ready      <= '0;
      r_crc_out    <= 8'h00;
      r_crc_valid  <= 1'b0;
      r_crc_id     <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_valid) begin
            r_grant               <= w_grant_next;
            r_last_grant          <= w_grant_next;
            r_ready               <= '0;
            r_ready[w_grant_next] <= 1'b1;
            r_busy                <= 1'b1;
            r_state               <= ST_RUN;
          end
        end
        ST_RUN: begin
          // A low granted valid simply stalls here; there is no timeout.
          if (w_fire && w_last) begin
            r_ready     <= '0;
            r_crc_out   <= w_crc_next;
            r_crc_id    <= r_grant;
            r_crc_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_crc_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_ready     <= '0;
          r_crc_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req0_ready = r_ready[0];
  assign req1_ready = r_ready[1];
  assign crc_out    = r_crc_out;
  assign crc_valid  = r_crc_valid;
  assign crc_id     = r_crc_id;
  assign busy       = r_busy;

endmodule

// File: tb/tb_crc8_frame_arbiter.sv
// -----------------------------------------------------------------------------
// tb_crc8_frame_arbiter
// Directed self-checking bench for crc8_frame_arbiter. Expected CRCs are
// hand-computed CRC-8 (poly 0x07, init 0x00, MSB-first, no reflection):
//   {0x01} -> 0x07, {0x00} -> 0x00, "123" -> 0xC0, "123456789" -> 0xF4.
// -----------------------------------------------------------------------------
module tb_crc8_frame_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_last, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] req1_data;
  logic [7:0] crc_out;
  logic       crc_valid, crc_id, busy;

  crc8_frame_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_last  (req0_last),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_last  (req1_last),
    .req1_ready (req1_ready),
    .crc_out    (crc_out),
    .crc_valid  (crc_valid),
    .crc_id     (crc_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Record of every cycle on which crc_valid is seen high.
  logic [7:0] q_crc[$];
  logic       q_id[$];
  int         q_cyc[$];
  int         both_ready_cnt = 0;
  int         r1_pre_cnt     = 0;
  int         r1_base        = -1;

  always @(negedge clk) begin
    if (crc_valid) begin
      q_crc.push_back(crc_out);
      q_id.push_back(crc_id);
      q_cyc.push_back(cyc);
    end
    if (req0_ready && req1_ready) both_ready_cnt <= both_ready_cnt + 1;
    if (req1_ready && (q_crc.size() == r1_base)) r1_pre_cnt <= r1_pre_cnt + 1;
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int id);
    return (id == 1) ? req1_ready : req0_ready;
  endfunction

  task automatic drive(input int id, input logic v, input logic [7:0] d, input logic l);
    if (id == 1) begin
      req1_valid = v; req1_data = d; req1_last = l;
    end else begin
      req0_valid = v; req0_data = d; req0_last = l;
    end
  endtask

  // Streams n bytes from requester id; gap = idle cycles between bytes.
  task automatic send(input int id, input logic [7:0] b [16], input int n,
                      input int gap, input bit with_last);
    for (int i = 0; i < n; i++) begin
      int t;
      @(negedge clk);
      drive(id, 1'b1, b[i], with_last && (i == n - 1));
      t = 0;
      while (!rdy(id) && t < 64) begin
        @(negedge clk);
        t++;
      end
      check($sformatf("ready_wait_r%0d_b%0d", id, i), 32'(t < 64), 32'd1);
      if (t >= 64) begin
        drive(id, 1'b0, 8'h00, 1'b0);
        return;
      end
      @(posedge clk);
      if (gap > 0) begin
        @(negedge clk);
        drive(id, 1'b0, 8'h00, 1'b0);
        repeat (gap - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    drive(id, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_pulses(input string tag, input int n);
    int t = 0;
    while (q_crc.size() < n && t < 200) begin
      @(posedge clk);
      t++;
    end
    check({tag, "_pulse_seen"}, 32'(q_crc.size() >= n), 32'd1);
  endtask

  task automatic check_pulse(input string tag, input int k, input logic [7:0] exp_crc,
                             input logic exp_id);
    if (k < q_crc.size()) begin
      check({tag, "_crc"}, 32'(q_crc[k]), 32'(exp_crc));
      check({tag, "_id"},  32'(q_id[k]),  32'(exp_id));
    end else begin
      check({tag, "_missing"}, 32'(q_crc.size()), 32'(k + 1));
    end
  endtask

  logic [7:0] s9 [16];
  logic [7:0] s3 [16];
  logic [7:0] b01[16];
  logic [7:0] b00[16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    for (int i = 0; i < 16; i++) begin
      s9[i] = 8'h00; s3[i] = 8'h00; b01[i] = 8'h00; b00[i] = 8'h00;
    end
    for (int i = 0; i < 9; i++) s9[i] = 8'(8'h31 + i);
    for (int i = 0; i < 3; i++) s3[i] = 8'(8'h31 + i);
    b01[0] = 8'h01;

    reset = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    #2 reset = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_crc_out",   32'(crc_out),    32'h00);
    check("rst_crc_valid", 32'(crc_valid),  32'd0);
    check("rst_crc_id",    32'(crc_id),     32'd0);
    check("rst_ready0",    32'(req0_ready), 32'd0);
    check("rst_ready1",    32'(req1_ready), 32'd0);
    check("rst_busy",      32'(busy),       32'd0);
    reset = 1'b0;

    // Single-byte frame 0x01 from requester 0
    send(0, b01, 1, 0, 1'b1);
    wait_pulses("t1", 1);
    check_pulse("t1", 0, 8'h07, 1'b0);
    repeat (5) @(negedge clk);
    check("t1_hold_crc",   32'(crc_out),      32'h07);
    check("t1_valid_low",  32'(crc_valid),    32'd0);
    check("t1_busy_low",   32'(busy),         32'd0);
    check("t1_pulse_cnt",  32'(q_crc.size()), 32'd1);

    // "123456789" from requester 1
    send(1, s9, 9, 0, 1'b1);
    wait_pulses("t2", 2);
    check_pulse("t2", 1, 8'hF4, 1'b1);

    // Tie just after reset: requester 0 first, then requester 1
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    n0 = q_crc.size();
    r1_base = n0;
    fork
      send(0, s3, 3, 0, 1'b1);
      send(1, b01, 1, 0, 1'b1);
    join
    wait_pulses("t3", n0 + 2);
    check_pulse("t3_first",  n0,     8'hC0, 1'b0);
    check_pulse("t3_second", n0 + 1, 8'h07, 1'b1);
    if (n0 + 1 < q_cyc.size())
      check("t3_gap", 32'(q_cyc[n0 + 1] - q_cyc[n0]), 32'd3);
    else
      check("t3_gap_missing", 32'(q_cyc.size()), 32'(n0 + 2));
    check("t3_r1_ready_during_r0", 32'(r1_pre_cnt), 32'd0);
    r1_base = -1;

    // "123" with 3 idle cycles between bytes
    n0 = q_crc.size();
    send(0, s3, 3, 3, 1'b1);
    wait_pulses("t4", n0 + 1);
    check_pulse("t4", n0, 8'hC0, 1'b0);
    repeat (6) @(negedge clk);
    check("t4_one_pulse", 32'(q_crc.size() - n0), 32'd1);

    // Reset after 4 bytes of "123456789", then full resend
    n0 = q_crc.size();
    send(1, s9, 4, 0, 1'b0);
    repeat (3) @(negedge clk);
    check("t5_stall_busy",   32'(busy),       32'd1);
    check("t5_stall_ready1", 32'(req1_ready), 32'd1);
    check("t5_stall_ready0", 32'(req0_ready), 32'd0);
    @(negedge clk) reset = 1'b1;
    #1;
    check("t5_rst_busy",    32'(busy),       32'd0);
    check("t5_rst_ready1",  32'(req1_ready), 32'd0);
    check("t5_rst_crc_out", 32'(crc_out),    32'h00);
    @(negedge clk) reset = 1'b0;
    check("t5_no_pulse", 32'(q_crc.size() - n0), 32'd0);
    send(1, s9, 9, 0, 1'b1);
    wait_pulses("t5", n0 + 1);
    check_pulse("t5", n0, 8'hF4, 1'b1);

    // Back-to-back single-byte frames 0x00 then 0x01 from requester 0
    n0 = q_crc.size();
    send(0, b00, 1, 0, 1'b1);
    send(0, b01, 1, 0, 1'b1);
    wait_pulses("t6", n0 + 2);
    check_pulse("t6_first",  n0,     8'h00, 1'b0);
    check_pulse("t6_second", n0 + 1, 8'h07, 1'b0);
    if (n0 + 1 < q_cyc.size())
      check("t6_gap_ge3", 32'((q_cyc[n0 + 1] - q_cyc[n0]) >= 3), 32'd1);
    else
      check("t6_gap_missing", 32'(q_cyc.size()), 32'(n0 + 2));

    repeat (3) @(negedge clk);
    check("ready_mutex", 32'(both_ready_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
